// File: rtl/fetch_unit.sv
// Instruction fetch: issues word-aligned imem requests and queues {pc, instr} for execute.
// Latency: request accepted in N, response written at the N+1 edge, instr valid in N+2 (no bypass).
// Backpressure: requests are credit-limited so FIFO entries plus outstanding requests never exceed DEPTH.
module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        i_reset,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] discard;
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   fifo_instr [DEPTH];
  logic [31:0]   fifo_pc    [DEPTH];

  logic [CW:0]   credit_used;
  logic          req_fire;
  logic          rsp_take;
  logic          rsp_drop;
  logic          push;
  logic          pop;
  logic [CW-1:0] inflight_after_rsp;
  logic [31:0]   redirect_target;
  logic          unused_redirect_lsbs;

  // The low two bits of the redirect target are forced to zero, so they are never consumed.
  assign unused_redirect_lsbs = ^i_redirect_pc[1:0];
  assign redirect_target      = {i_redirect_pc[31:2], 2'b00};

  // Credit: queued entries plus outstanding requests may not exceed the FIFO depth.
  assign credit_used      = {1'b0, count} + {1'b0, inflight};
  assign o_imem_req_valid = !i_redirect && (credit_used < DEPTH_C);
  assign o_imem_addr      = fetch_pc;
  assign req_fire         = o_imem_req_valid && i_imem_req_ready;

  // A response with nothing outstanding is a protocol violation and is ignored entirely.
  assign rsp_take = i_imem_rsp_valid && (inflight != '0);
  assign rsp_drop = rsp_take && (discard != '0);
  // A response landing in a redirect cycle belongs to the old stream and is dropped too.
  assign push     = rsp_take && (discard == '0) && !i_redirect;
  assign pop      = o_instr_valid && i_instr_ready;

  assign inflight_after_rsp = inflight - CW'(rsp_take);

  assign o_instr_valid = (count != '0);
  assign o_instruction = fifo_instr[rd_ptr];
  assign o_pc          = fifo_pc[rd_ptr];

  // Fetch/response bookkeeping; a redirect flushes the FIFO and marks everything in flight stale.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (i_redirect) begin
      fetch_pc <= redirect_target;
      rsp_pc   <= redirect_target;
      inflight <= inflight_after_rsp;
      discard  <= inflight_after_rsp;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      inflight <= inflight_after_rsp + CW'(req_fire);
      if (rsp_drop) begin
        discard <= discard - CW'(1);
      end
      if (push) begin
        rsp_pc <= rsp_pc + 32'd4;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage; cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else if (push) begin
      fifo_instr[wr_ptr] <= i_imem_rsp_data;
      fifo_pc[wr_ptr]    <= rsp_pc;
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the single-cycle RV32 core. It replaces the in-core `program_memory` array lookup with a bus-based instruction memory. It generates sequential word-aligned fetch addresses and buffers returned instructions, each paired with its PC, in a small FIFO. It presents them to the execute stage through a valid/ready handshake, and on a taken JAL/branch redirect it flushes everything in flight and restarts at the target.

## Interface
- `DEPTH`, 4: instruction FIFO entries, and also the maximum outstanding requests; power of 2, ≥2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `clk` in 1: clock, rising-edge.
- `i_reset` in 1: reset, asynchronous, active-low (0 = in reset).
- `o_imem_req_valid` out 1: fetch request valid.
- `i_imem_req_ready` in 1: memory accepts request.
- `o_imem_addr` out 32: fetch address, bits[1:0] always 0.
- `i_imem_rsp_valid` in 1: response data valid; responses return in request order, one per accepted request.
- `i_imem_rsp_data` in 32: instruction word.
- `o_instr_valid` out 1: FIFO head valid.
- `i_instr_ready` in 1: execute stage accepts head.
- `o_instruction` out 32: head instruction.
- `o_pc` out 32: PC of head instruction.
- `i_redirect` in 1: taken JAL/branch; flush and restart.
- `i_redirect_pc` in 32: restart PC; bits[1:0] ignored (treated as 0).

## Operation
- State:
  - `fetch_pc`: next address to request.
  - `rsp_pc`: PC of the next non-stale response.
  - `inflight`: accepted requests not yet answered.
  - `discard`: inflight responses to drop.
  - `count`: FIFO occupancy.
  - Counter width is clog2(DEPTH)+1.
- Request issue: `o_imem_req_valid` = `!i_redirect && (count + inflight < DEPTH)`. `o_imem_addr` = `fetch_pc`.
- On request handshake: `fetch_pc += 4` (32-bit wrap, 0xFFFF_FFFC → 0) and `inflight += 1`.
- On response:
  - `inflight -= 1`.
  - If `discard > 0`: `discard -= 1` and the data is dropped.
  - Otherwise: push {`rsp_pc`, `i_imem_rsp_data`} and `rsp_pc += 4`.
- Output: `o_instr_valid` = `count != 0`. On `o_instr_valid && i_instr_ready`, pop the head.
- Redirect, applied at the clock edge and overriding all other updates:
  - `count` ← 0.
  - `fetch_pc` ← `rsp_pc` ← `{i_redirect_pc[31:2],2'b00}`.
  - `discard` ← `inflight` after this cycle's response is counted. A response arriving in the redirect cycle is dropped.
- The credit rule guarantees the FIFO never overflows. A response arriving with `inflight == 0` is a protocol violation and is ignored with no state change.
- Simultaneous push and pop: `count` is unchanged and the FIFO pointers wrap modulo DEPTH.

## Timing
- Reset values:
  - `fetch_pc` = `rsp_pc` = RESET_PC.
  - All counters 0.
  - `o_instr_valid` = 0.
  - `o_imem_req_valid` = 1 as soon as `i_reset` = 1 (combinational on state).
  - `o_instruction`/`o_pc` read 0 from the cleared FIFO.
- Reset asserted mid-operation clears all state immediately. Responses to pre-reset requests are a system-level error; memory is reset together with this block.
- With 1-cycle memory:
  - Request accepted in cycle N.
  - Response in N+1, written at the N+1 edge.
  - `o_instr_valid` high in N+2. There is no FIFO bypass.
- Sustained throughput is 1 instruction/cycle when DEPTH ≥ 3, memory is 1-cycle, and `i_instr_ready` = 1.
- Redirect in cycle R:
  - No request is issued in R.
  - A request for the target issues in R+1, if credit allows.
  - The first target instruction is valid no earlier than R+3.
- A pop that coincides with `i_redirect` counts as completed; ignoring it is the execute stage's responsibility.
- `o_imem_req_valid` and `o_imem_addr` hold stable while not accepted, unless `i_redirect` is high.

## Test plan
- Reset release, 1-cycle memory, `i_instr_ready` = 1 → requests 0x0, 0x4, 0x8… on consecutive cycles. The first instruction appears 2 cycles after the first request handshake with `o_pc` = 0x0, then one instruction per cycle with PCs incrementing by 4.
- `i_instr_ready` = 0 for 10 cycles → exactly DEPTH requests are issued, then `o_imem_req_valid` = 0. On release, instructions are delivered in order with no loss or duplication.
- Redirect to 0x103 while 3 requests are outstanding with 3-cycle memory latency → the 3 stale responses are dropped. The next request address is 0x100, and the first output has `o_pc` = 0x100.
- Redirect coinciding with a response and a pop → that response is dropped, the FIFO is empty next cycle, and `fetch_pc` = target.
- Memory stalls `i_imem_req_ready` = 0 for 5 cycles → `o_imem_addr` is held constant and `fetch_pc` does not advance.
- `i_reset` pulled low mid-stream with FIFO full → outputs return to reset values asynchronously. After release, fetch resumes at RESET_PC.
